mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 124 ++++++++++++
 tb/tb_mult_div_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the MIPS HI/LO registers.
// Operands and op are latched at the start edge; the result is computed
// combinationally from the latches and committed to HI/LO on the edge
// where the run counter reaches zero, which is also the edge busy falls.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      a_q, b_q;
    logic [2:0]       op_q;

    // Products: sign-extending to 64 bits and keeping the low 64 bits of the
    // product gives the two's-complement signed result.
    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Divisor forced to 1 on zero so the datapath never yields X; the commit
    // is suppressed for b == 0 anyway.
    logic        b_zero;
    logic [31:0] den_u, abs_a, abs_b, den_s;
    logic [31:0] divu_q, divu_r, mag_q, mag_r, div_q, div_r;
    assign b_zero = (b_q == 32'd0);
    assign den_u  = b_zero ? 32'd1 : b_q;
    assign divu_q = a_q / den_u;
    assign divu_r = a_q % den_u;

    // Signed divide on magnitudes; quotient sign is the XOR of operand signs,
    // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000 r 0.
    assign abs_a = a_q[31] ? (32'd0 - a_q) : a_q;
    assign abs_b = b_q[31] ? (32'd0 - b_q) : b_q;
    assign den_s = b_zero ? 32'd1 : abs_b;
    assign mag_q = abs_a / den_s;
    assign mag_r = abs_a % den_s;
    assign div_q = (a_q[31] ^ b_q[31]) ? (32'd0 - mag_q) : mag_q;
    assign div_r = a_q[31] ? (32'd0 - mag_r) : mag_r;

    assign busy = (state == RUN);

    // Control FSM, operand latches and HI/LO commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                a_q   <= a;
                                b_q   <= b;
                                op_q  <= op;
                                cnt   <= CNT_W'(MULT_CYCLES);
                                state <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                a_q   <= a;
                                b_q   <= b;
                                op_q  <= op;
                                cnt   <= CNT_W'(DIV_CYCLES);
                                state <= RUN;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        case (op_q)
                            OP_MULT:  {hi, lo} <= prod_s;
                            OP_MULTU: {hi, lo} <= prod_u;
                            OP_DIV: if (!b_zero) begin
                                hi <= div_r;
                                lo <= div_q;
                            end
                            OP_DIVU: if (!b_zero) begin
                                hi <= divu_r;
                                lo <= divu_q;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a table of operations with
// hand-computed HI/LO results and busy lengths, a scoreboard queue of
// expected {hi,lo}, and hand-written sequences for mid-run disturbance,
// back-to-back issue and reset during a divide.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [63:0] sb[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    vec_t vecs[14];

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue one op at the current negedge, count busy cycles, check HI/LO hold
    // while busy, then pop the scoreboard and compare the committed result.
    // Returns at the negedge where busy is low, so a following call issues
    // back-to-back. With disturb set, a mthi pulse and operand changes are
    // injected mid-run.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo,
                          input int ecyc, input bit disturb);
        logic [31:0] h0, l0;
        logic [63:0] exp;
        int cnt;
        bit hold_ok;
        h0 = hi;
        l0 = lo;
        start = 1'b1; op = o; a = va; b = vb;
        sb.push_back({ehi, elo});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom;
        cnt = 0;
        hold_ok = 1'b1;
        while (busy && cnt < 64) begin
            cnt++;
            if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
            if (disturb && cnt == 2) begin
                start = 1'b1; op = 3'd4; a = 32'hDEADBEEF; b = 32'h0BADF00D;
            end
            if (disturb && cnt == 3) begin
                start = 1'b0; a = 32'h11111111; b = 32'h22222222;
            end
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 64'(cnt), 64'(ecyc));
        if (ecyc > 0) check({name, "_hold"}, 64'(hold_ok), 64'd1);
        exp = sb.pop_front();
        check({name, "_hilo"}, {hi, lo}, exp);
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10};
        vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        vecs[6]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[7]  = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
        vecs[8]  = '{3'd4, 32'h00001234, 32'd0,        32'h00001234, 32'h00000000, 0};
        vecs[9]  = '{3'd5, 32'h00005678, 32'd0,        32'h00001234, 32'h00005678, 0};
        vecs[10] = '{3'd2, 32'd5,        32'd0,        32'h00001234, 32'h00005678, 10};
        vecs[11] = '{3'd3, 32'd9,        32'd0,        32'h00001234, 32'h00005678, 10};
        vecs[12] = '{3'd6, 32'hFFFFFFFF, 32'd1,        32'h00001234, 32'h00005678, 0};
        vecs[13] = '{3'd7, 32'hAAAAAAAA, 32'd1,        32'h00001234, 32'h00005678, 0};

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].cycles, 1'b0);

        // mult with mid-run mthi pulse and operand changes, then a div issued
        // in the first cycle after busy falls.
        run_op("mult_disturb", 3'd0, 32'd6, 32'd7, 32'h0, 32'd42, 5, 1'b1);
        run_op("div_b2b", 3'd2, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b0);

        // Reset during the third busy cycle of a div.
        begin
            bit quiet;
            start = 1'b1; op = 3'd2; a = 32'd50; b = 32'd3;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            check("rst_pre_busy", 64'(busy), 64'd1);
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
            #1;
            check("rst_mid_busy", 64'(busy), 64'd0);
            check("rst_mid_hilo", {hi, lo}, 64'd0);
            @(negedge clk);
            reset = 1'b0;
            quiet = 1'b1;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) quiet = 1'b0;
            end
            check("rst_no_late_commit", 64'(quiet), 64'd1);
        end

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
